// File: rtl/cond_delay_xor_if.sv
// Channel bundle for cond_delay_xor: inputs a/b and outputs x/busy (+ rej when
// CDX_REJECT_CNT_EN is defined). The master drives a/b; the slave is the XOR block.
interface cond_delay_xor_if #(
  parameter int CH = 4
);
  logic [CH-1:0] a;
  logic [CH-1:0] b;
  logic [CH-1:0] x;
  logic [CH-1:0] busy;
`ifdef CDX_REJECT_CNT_EN
  logic [15:0]   rej;

  modport master (output a, b, input  x, busy, rej);
  modport slave  (input  a, b, output x, busy, rej);
`else
  modport master (output a, b, input  x, busy);
  modport slave  (input  a, b, output x, busy);
`endif
endinterface

// File: rtl/cond_delay_xor.sv
// Multi-channel clocked XOR with inertial, path-dependent latency per channel.
// Optional glitch-reject counter on bus.rej when CDX_REJECT_CNT_EN is defined.
module cond_delay_xor #(
  parameter int CH       = 4,
  parameter int DW       = 6,
  parameter int DLY_A_HI = 10,
  parameter int DLY_A_LO = 21,
  parameter int DLY_B    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  cond_delay_xor_if.slave  bus
);

  // When a and b both change the target is unchanged, but the delay still matters for cancel.
  localparam int DLY_AB_HI = (DLY_A_HI > DLY_B) ? DLY_A_HI : DLY_B;
  localparam int DLY_AB_LO = (DLY_A_LO > DLY_B) ? DLY_A_LO : DLY_B;

  if (DLY_A_HI < 1 || DLY_A_HI >= 2**DW ||
      DLY_A_LO < 1 || DLY_A_LO >= 2**DW ||
      DLY_B    < 1 || DLY_B    >= 2**DW) begin : g_bad_dly
    $error("cond_delay_xor: every delay must lie in 1..2**DW-1");
  end

  logic [CH-1:0] r_a_q;
  logic [CH-1:0] r_b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_q <= '0;
      r_b_q <= '0;
    end else begin
      r_a_q <= bus.a;
      r_b_q <= bus.b;
    end
  end

`ifdef CDX_REJECT_CNT_EN
  logic [CH-1:0] w_cancel;
`endif

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic          w_a_chg;
    logic          w_b_chg;
    logic          w_ev;
    logic          w_tgt;
    logic [DW-1:0] w_dly;
    logic          r_x;
    logic          r_busy;
    logic          r_tgt;
    logic [DW-1:0] r_cnt;

    always_comb begin
      w_a_chg = bus.a[gi] ^ r_a_q[gi];
      w_b_chg = bus.b[gi] ^ r_b_q[gi];
      w_ev    = w_a_chg | w_b_chg;
      w_tgt   = bus.a[gi] ^ bus.b[gi];
      w_dly   = DW'(DLY_B);
      if (w_a_chg && w_b_chg) begin
        w_dly = bus.a[gi] ? DW'(DLY_AB_HI) : DW'(DLY_AB_LO);
      end else if (w_a_chg) begin
        w_dly = bus.a[gi] ? DW'(DLY_A_HI) : DW'(DLY_A_LO);
      end
    end

    // Counter holds the edges remaining; the edge that sees 1 applies the target.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_x    <= 1'b0;
        r_busy <= 1'b0;
        r_tgt  <= 1'b0;
        r_cnt  <= '0;
      end else if (w_ev && (w_tgt != r_x)) begin
        r_busy <= 1'b1;
        r_tgt  <= w_tgt;
        r_cnt  <= w_dly;
      end else if (w_ev && r_busy) begin
        r_busy <= 1'b0;
      end else if (r_busy) begin
        if (r_cnt == DW'(1)) begin
          r_x    <= r_tgt;
          r_busy <= 1'b0;
        end else begin
          r_cnt  <= r_cnt - DW'(1);
        end
      end
    end

    assign bus.x[gi]    = r_x;
    assign bus.busy[gi] = r_busy;
`ifdef CDX_REJECT_CNT_EN
    assign w_cancel[gi] = w_ev && (w_tgt == r_x) && r_busy;
`endif
  end

`ifdef CDX_REJECT_CNT_EN
  logic [15:0] r_rej;
  logic [16:0] w_ncancel;
  logic [16:0] w_rej_sum;

  always_comb begin
    w_ncancel = '0;
    for (int i = 0; i < CH; i++) begin
      w_ncancel = w_ncancel + 17'(w_cancel[i]);
    end
    w_rej_sum = {1'b0, r_rej} + w_ncancel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rej <= '0;
    end else if (w_rej_sum[16]) begin
      r_rej <= 16'hFFFF;
    end else begin
      r_rej <= w_rej_sum[15:0];
    end
  end

  assign bus.rej = r_rej;
`endif

endmodule

// File: tb/tb_cond_delay_xor.sv
// Scoreboard bench for cond_delay_xor: an event-time reference model pushes the
// expected x/busy/rej after every edge; a negedge monitor pops and compares.
module tb_cond_delay_xor;
  localparam int CH = 4;

  logic clk;
  logic rst_n;

  cond_delay_xor_if #(.CH(CH)) bus ();

  cond_delay_xor #(
    .CH(CH), .DW(6), .DLY_A_HI(10), .DLY_A_LO(21), .DLY_B(12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] x;
    logic [CH-1:0] busy;
    logic [15:0]   rej;
    int            edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: each pending update is a (target, absolute due edge) pair.
  bit m_x   [CH];
  bit m_pend[CH];
  bit m_tgt [CH];
  int m_due [CH];
  bit m_aq  [CH];
  bit m_bq  [CH];
  int m_rej;
  int edge_n;

  function automatic int path_delay(bit a_chg, bit b_chg, bit a_new);
    int da;
    da = a_new ? 10 : 21;
    if (a_chg && b_chg) return (da > 12) ? da : 12;
    if (a_chg) return da;
    return 12;
  endfunction

  task automatic model_edge();
    exp_t e;
    edge_n++;
    for (int i = 0; i < CH; i++) begin
      bit an, bn, ac, bc, tgt;
      an = bus.a[i];
      bn = bus.b[i];
      if (!rst_n) begin
        m_x[i] = 0; m_pend[i] = 0; m_tgt[i] = 0; m_aq[i] = 0; m_bq[i] = 0;
      end else begin
        ac  = (an != m_aq[i]);
        bc  = (bn != m_bq[i]);
        tgt = an ^ bn;
        if (ac || bc) begin
          if (tgt != m_x[i]) begin
            m_pend[i] = 1;
            m_tgt[i]  = tgt;
            m_due[i]  = edge_n + path_delay(ac, bc, an);
          end else if (m_pend[i]) begin
            m_pend[i] = 0;
            if (m_rej < 16'hFFFF) m_rej++;
          end
        end else if (m_pend[i] && edge_n == m_due[i]) begin
          m_x[i]    = m_tgt[i];
          m_pend[i] = 0;
        end
        m_aq[i] = an;
        m_bq[i] = bn;
      end
    end
    if (!rst_n) m_rej = 0;
    for (int i = 0; i < CH; i++) begin
      e.x[i]    = m_x[i];
      e.busy[i] = m_pend[i];
    end
    e.rej     = 16'(m_rej);
    e.edge_no = edge_n;
    exp_q.push_back(e);
  endtask

  // Apply inputs, let one edge pass, record the expectation, return at negedge.
  task automatic drive(input logic [CH-1:0] av, input logic [CH-1:0] bv,
                       input logic rv, input int n);
    for (int k = 0; k < n; k++) begin
      bus.a = av;
      bus.b = bv;
      rst_n = rv;
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (bus.x === e.x) && (bus.busy === e.busy);
`ifdef CDX_REJECT_CNT_EN
      ok = ok && (bus.rej === e.rej);
`endif
      n_checks++;
      if (!ok) begin
        n_fail++;
`ifdef CDX_REJECT_CNT_EN
        $display("FAIL edge%0d: x=%h busy=%h rej=%0d, required x=%h busy=%h rej=%0d",
                 e.edge_no, bus.x, bus.busy, bus.rej, e.x, e.busy, e.rej);
`else
        $display("FAIL edge%0d: x=%h busy=%h, required x=%h busy=%h",
                 e.edge_no, bus.x, bus.busy, e.x, e.busy);
`endif
      end else begin
        $display("edge%0d a=%h b=%h rst_n=%b x=%h busy=%h", e.edge_no,
                 bus.a, bus.b, rst_n, bus.x, bus.busy);
      end
    end
  end

  initial begin
    logic [CH-1:0] ra, rb;
    edge_n = 0;
    m_rej  = 0;
    for (int i = 0; i < CH; i++) begin
      m_x[i] = 0; m_pend[i] = 0; m_tgt[i] = 0; m_due[i] = 0; m_aq[i] = 0; m_bq[i] = 0;
    end

    // Reset hold then release: all channels rise 10 edges later.
    drive(4'hF, 4'h0, 1'b0, 3);
    drive(4'hF, 4'h0, 1'b1, 14);
    // Fall on A_LO path, rise on A_HI path, rise on B path.
    drive(4'h0, 4'h0, 1'b1, 25);
    drive(4'h1, 4'h0, 1'b1, 14);
    drive(4'h0, 4'h0, 1'b1, 25);
    drive(4'h0, 4'h1, 1'b1, 15);
    // ch1 glitch reject.
    drive(4'h2, 4'h1, 1'b1, 4);
    drive(4'h0, 4'h1, 1'b1, 5);
    // ch2 cancel by b, then inertial restart.
    drive(4'h4, 4'h1, 1'b1, 5);
    drive(4'h4, 4'h5, 1'b1, 5);
    drive(4'h0, 4'h1, 1'b1, 25);
    drive(4'h4, 4'h1, 1'b1, 1);
    drive(4'h0, 4'h1, 1'b1, 1);
    drive(4'h4, 4'h1, 1'b1, 15);
    // Reset while every channel is busy; nothing stale afterwards.
    drive(4'h0, 4'h0, 1'b1, 25);
    drive(4'hF, 4'h0, 1'b1, 3);
    drive(4'h0, 4'h0, 1'b0, 1);
    drive(4'h0, 4'h0, 1'b1, 32);

    // Random sparse toggling with occasional resets.
    ra = 4'h0;
    rb = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 19) == 0) ra[i] = ~ra[i];
        if ($urandom_range(0, 24) == 0) rb[i] = ~rb[i];
      end
      drive(ra, rb, ($urandom_range(0, 699) != 0), 1);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
